// File: rtl/wta_column_ctrl_if.sv
// Bundle of sample-sequencer and neuron-array signals for the WTA column controller.
// The controller connects via the slave modport; the environment driving start,
// spikes and winner_ack connects via the master modport.
interface wta_column_ctrl_if #(
    parameter int NEURONS = 4,
    parameter int IDX_W   = 2
);
    logic               start;
    logic               sample_ready;
    logic [NEURONS-1:0] spikes;
    logic               signal_en;
    logic               latinhib;
    logic [NEURONS-1:0] neuron_rstb;
    logic               winner_valid;
    logic [IDX_W-1:0]   winner_idx;
    logic               winner_none;
    logic               winner_ack;
    logic               busy;

    modport master (
        output start, spikes, winner_ack,
        input  sample_ready, signal_en, latinhib, neuron_rstb,
               winner_valid, winner_idx, winner_none, busy
    );

    modport slave (
        input  start, spikes, winner_ack,
        output sample_ready, signal_en, latinhib, neuron_rstb,
               winner_valid, winner_idx, winner_none, busy
    );
endinterface

// File: rtl/wta_column_ctrl.sv
// Winner-take-all column controller: clears the neurons, opens a bounded
// presentation window, latches the first spiking neuron, holds lateral
// inhibition for a refractory period and reports the winner with valid/ack.
// Every output is a flop decoded from the next state, so nothing is
// combinational from inputs to outputs.
// Optional macro WTA_RR_EN: round-robin tie-break instead of lowest-index-wins.
module wta_column_ctrl #(
    parameter int NEURONS      = 4,
    parameter int IDX_W        = 2,
    parameter int WIN_CYCLES   = 64,
    parameter int INHIB_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rstb,
    wta_column_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PRESENT,
        INHIBIT,
        REPORT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   winner_idx_q, winner_idx_d;
    logic               winner_none_q, winner_none_d;

    logic               sample_ready_q, sample_ready_d;
    logic               signal_en_q, signal_en_d;
    logic               latinhib_q, latinhib_d;
    logic [NEURONS-1:0] neuron_rstb_q, neuron_rstb_d;
    logic               winner_valid_q, winner_valid_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   pick;
    logic               any_spike;

    assign any_spike = |bus.spikes;

`ifdef WTA_RR_EN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               found;
    logic [IDX_W-1:0]   probe;

    // Round-robin search: start at the pointer and wrap modulo NEURONS
    always_comb begin
        pick  = '0;
        found = 1'b0;
        probe = '0;
        for (int i = 0; i < NEURONS; i++) begin
            probe = IDX_W'((int'(rr_ptr_q) + i) % NEURONS);
            if (!found && bus.spikes[probe]) begin
                pick  = probe;
                found = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner after each real win
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == PRESENT && any_spike) begin
            rr_ptr_d = IDX_W'((int'(pick) + 1) % NEURONS);
        end
    end

    // Pointer register, cleared by reset
    always_ff @(posedge clk) begin
        if (rstb) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    // Fixed priority: scan downward so the lowest set index is the last write
    always_comb begin
        pick = '0;
        for (int i = NEURONS - 1; i >= 0; i--) begin
            if (bus.spikes[i]) begin
                pick = IDX_W'(i);
            end
        end
    end
`endif

    // Next-state, counter and winner capture
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        winner_idx_d  = winner_idx_q;
        winner_none_d = winner_none_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                cnt_d         = '0;
                winner_none_d = 1'b0;
                state_d       = PRESENT;
            end
            PRESENT: begin
                if (any_spike) begin
                    winner_idx_d  = pick;
                    winner_none_d = 1'b0;
                    cnt_d         = '0;
                    state_d       = INHIBIT;
                end else if (cnt_q == CNT_W'(WIN_CYCLES - 1)) begin
                    winner_idx_d  = '0;
                    winner_none_d = 1'b1;
                    state_d       = REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            INHIBIT: begin
                if (cnt_q == CNT_W'(INHIB_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = REPORT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            REPORT: begin
                if (bus.winner_ack) begin
                    winner_none_d = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Moore output decode from the state being entered, registered below
    always_comb begin
        sample_ready_d = (state_d == IDLE);
        signal_en_d    = (state_d == PRESENT);
        latinhib_d     = (state_d == INHIBIT);
        neuron_rstb_d  = (state_d == CLEAR) ? '0 : '1;
        winner_valid_d = (state_d == REPORT);
        busy_d         = (state_d != IDLE);
    end

    // State, counter, result and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            winner_idx_q   <= '0;
            winner_none_q  <= 1'b0;
            sample_ready_q <= 1'b0;
            signal_en_q    <= 1'b0;
            latinhib_q     <= 1'b0;
            neuron_rstb_q  <= '0;
            winner_valid_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            winner_idx_q   <= winner_idx_d;
            winner_none_q  <= winner_none_d;
            sample_ready_q <= sample_ready_d;
            signal_en_q    <= signal_en_d;
            latinhib_q     <= latinhib_d;
            neuron_rstb_q  <= neuron_rstb_d;
            winner_valid_q <= winner_valid_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.sample_ready = sample_ready_q;
    assign bus.signal_en    = signal_en_q;
    assign bus.latinhib     = latinhib_q;
    assign bus.neuron_rstb  = neuron_rstb_q;
    assign bus.winner_valid = winner_valid_q;
    assign bus.winner_idx   = winner_idx_q;
    assign bus.winner_none  = winner_none_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_wta_column_ctrl.sv
// Directed bench for wta_column_ctrl (NEURONS=4, WIN_CYCLES=8, INHIB_CYCLES=4).
// Expected winners are queued when a sample is launched and popped when
// winner_valid appears.
module tb_wta_column_ctrl;

    logic clk;
    logic rstb;

    int checks;
    int errors;

    logic [2:0] expQ[$];

    wta_column_ctrl_if #(.NEURONS(4), .IDX_W(2)) bus ();

    wta_column_ctrl #(
        .NEURONS      (4),
        .IDX_W        (2),
        .WIN_CYCLES   (8),
        .INHIB_CYCLES (4),
        .CNT_W        (16)
    ) dut (
        .clk  (clk),
        .rstb (rstb),
        .bus  (bus)
    );

    // Free-running clock, 10 time units per cycle
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic doReset();
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
    endtask

    // Launch one sample, present vec on PRESENT cycle spikeAt (0 = never),
    // then hold the result holdCycles before acknowledging it.
    task automatic applyStimulus(input logic [3:0] vec, input int spikeAt,
                                 input logic [1:0] expIdx, input logic expNone,
                                 input int expEn, input int expInh, input int expLat,
                                 input int holdCycles, input bit pokeStart,
                                 input string tag);
        int enCnt;
        int inhCnt;
        int lat;
        bit got;
        bit overlap;
        logic [2:0] exp;
        expQ.push_back({expNone, expIdx});
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput({tag, "_clear"}, {bus.neuron_rstb, bus.busy, bus.sample_ready, bus.signal_en},
                    {4'b0000, 1'b1, 1'b0, 1'b0});
        enCnt   = 0;
        inhCnt  = 0;
        lat     = 1;
        got     = 1'b0;
        overlap = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            lat++;
            bus.spikes = '0;
            if (bus.signal_en) enCnt++;
            if (bus.latinhib) inhCnt++;
            if (bus.signal_en && bus.latinhib) overlap = 1'b1;
            if (bus.signal_en && enCnt == spikeAt) bus.spikes = vec;
            if (bus.winner_valid) begin
                got = 1'b1;
                break;
            end
        end
        checkOutput({tag, "_valid_seen"}, 32'(got), 32'd1);
        checkOutput({tag, "_overlap"}, 32'(overlap), 32'd0);
        exp = expQ.pop_front();
        checkOutput({tag, "_idx"}, 32'(bus.winner_idx), 32'(exp[1:0]));
        checkOutput({tag, "_none"}, 32'(bus.winner_none), 32'(exp[2]));
        checkOutput({tag, "_en_cycles"}, enCnt, expEn);
        checkOutput({tag, "_inhib_cycles"}, inhCnt, expInh);
        checkOutput({tag, "_latency"}, lat, expLat);
        for (int h = 0; h < holdCycles; h++) begin
            if (pokeStart) bus.start = 1'b1;
            @(negedge clk);
            checkOutput({tag, "_hold"}, {bus.winner_valid, bus.winner_none, bus.winner_idx, bus.busy},
                        {1'b1, exp[2], exp[1:0], 1'b1});
        end
        bus.winner_ack = 1'b1;
        @(negedge clk);
        bus.winner_ack = 1'b0;
        bus.start      = 1'b0;
        checkOutput({tag, "_after_ack"}, {bus.winner_valid, bus.winner_none, bus.sample_ready, bus.busy},
                    4'b0010);
    endtask

    initial begin
        logic [1:0] rrExp[3];
        bit sawActivity;
`ifdef WTA_RR_EN
        rrExp[0] = 2'd0; rrExp[1] = 2'd1; rrExp[2] = 2'd2;
`else
        rrExp[0] = 2'd0; rrExp[1] = 2'd0; rrExp[2] = 2'd0;
`endif
        checks         = 0;
        errors         = 0;
        rstb           = 1'b1;
        bus.start      = 1'b0;
        bus.spikes     = '0;
        bus.winner_ack = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_outputs",
                    {bus.sample_ready, bus.signal_en, bus.latinhib, bus.neuron_rstb,
                     bus.winner_valid, bus.winner_idx, bus.winner_none, bus.busy}, 32'd0);
        rstb = 1'b0;
        @(negedge clk);
        checkOutput("idle_after_reset", {bus.sample_ready, bus.neuron_rstb, bus.busy}, 6'b1_1111_0);

        $display("[TB] single win");
        applyStimulus(4'b0100, 5, 2'd2, 1'b0, 5, 4, 11, 0, 1'b0, "win");

        $display("[TB] timeout");
        applyStimulus(4'b0000, 0, 2'd0, 1'b1, 8, 0, 10, 0, 1'b0, "timeout");

        $display("[TB] spike in last window cycle");
        applyStimulus(4'b1000, 8, 2'd3, 1'b0, 8, 4, 14, 0, 1'b0, "lastcycle");

        $display("[TB] tie with held ack and start during report");
        doReset();
        applyStimulus(4'b1010, 2, 2'd1, 1'b0, 2, 4, 8, 6, 1'b1, "tie");
        sawActivity = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || !bus.sample_ready) sawActivity = 1'b1;
        end
        checkOutput("start_in_report_ignored", 32'(sawActivity), 32'd0);

        $display("[TB] all neurons spike together, three samples");
        doReset();
        for (int s = 0; s < 3; s++) begin
            applyStimulus(4'b1111, 1, rrExp[s], 1'b0, 1, 4, 7, 0, 1'b0, $sformatf("allspike%0d", s));
        end

        $display("[TB] reset during inhibit");
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.spikes = 4'b0001;
        @(negedge clk);
        bus.spikes = 4'b0000;
        checkOutput("abort_inhibit_entered", 32'(bus.latinhib), 32'd1);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        checkOutput("abort_outputs", {bus.latinhib, bus.winner_valid, bus.neuron_rstb, bus.busy},
                    7'b0_0_0000_0);
        rstb = 1'b0;
        sawActivity = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.winner_valid || bus.busy || bus.latinhib) sawActivity = 1'b1;
        end
        checkOutput("abort_no_result", 32'(sawActivity), 32'd0);

        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wta_column_ctrl.md
Name: wta_column_ctrl

Overview:
Sequencing controller for a column of NEURONS integrate-and-fire neurons that share one lateral-inhibition bus. Per sample, it:
- clears the neurons;
- gates input presentation for a bounded window;
- picks the first neuron to spike (winner-take-all);
- drives the inhibition bus for a refractory period;
- reports the winner index via a valid/ack handshake.

It sits between the sample sequencer and the neuron array.

Parameters:
NEURONS, 4, number of neurons in the column (2..16)
IDX_W, 2, winner index width; NEURONS <= 2**IDX_W
WIN_CYCLES, 64, presentation window length in clk cycles (1..65535)
INHIB_CYCLES, 4, cycles latinhib is held after a win (1..65535)
CNT_W, 16, width of the internal cycle counter

Ports:
clk  in  1  system clock, all logic on rising edge
rstb  in  1  reset; synchronous, active-high (name kept per codebase convention)
start  in  1  request to process one sample; honoured only in IDLE
sample_ready  out  1  high in IDLE
spikes  in  NEURONS  neuron spike outputs; synchronous to clk, sampled as levels at posedge
signal_en  out  1  gates input signals into the neurons; high only in PRESENT
latinhib  out  1  lateral-inhibition bus drive; high only in INHIBIT
neuron_rstb  out  NEURONS  active-low neuron clear; all bits low in CLEAR and during reset
winner_valid  out  1  result valid; high in REPORT
winner_idx  out  IDX_W  winning neuron index; held stable while winner_valid
winner_none  out  1  window expired with no spike; qualified by winner_valid
winner_ack  in  1  consumer accepts result
busy  out  1  high in every state except IDLE

Behaviour:
- All outputs are registered and Moore-decoded from state. There are no combinational paths from inputs to outputs.
- Reset (rstb=1 at posedge):
  - state goes to IDLE and the counter goes to 0.
  - Reset values: signal_en=0, latinhib=0, neuron_rstb=all 0, winner_valid=0, winner_idx=0, winner_none=0, busy=0, sample_ready=0.
  - First cycle after reset: sample_ready=1, neuron_rstb=all 1.
  - Reset mid-operation aborts immediately and discards any pending result.
- IDLE:
  - sample_ready=1, neuron_rstb=all 1.
  - start=1 -> CLEAR.
- CLEAR (exactly 1 cycle):
  - neuron_rstb=all 0, counter<=0.
  - Then -> PRESENT.
- PRESENT:
  - signal_en=1; counter increments each cycle.
  - If any spikes bit=1, the winner is latched from the sampled vector and the state goes -> INHIBIT.
  - Tie-break among simultaneous spikes: lowest index wins (see Optional Feature).
  - If no spike and counter==WIN_CYCLES-1, then winner_none<=1, winner_idx<=0, and the state goes -> REPORT (skips INHIBIT).
  - PRESENT lasts at most WIN_CYCLES cycles.
  - A spike in the last window cycle counts as a win, not a timeout.
- INHIBIT:
  - latinhib=1, signal_en=0, counter reloaded to 0.
  - Held exactly INHIB_CYCLES cycles, then -> REPORT.
- REPORT:
  - winner_valid=1; winner_idx and winner_none are stable.
  - winner_ack=1 -> IDLE next cycle, which clears winner_valid and winner_none.
  - winner_ack in the first REPORT cycle is accepted.
  - winner_ack outside REPORT is ignored.
- Spikes outside PRESENT are ignored. start outside IDLE is ignored (not queued).
- Latency: start sampled at cycle t, then CLEAR at t+1 and first PRESENT cycle at t+2.
  - A spike sampled in PRESENT cycle t+2+k gives INHIBIT from t+3+k and winner_valid from t+3+k+INHIB_CYCLES.
  - Timeout gives winner_valid at t+2+WIN_CYCLES.
- Arithmetic: counter is unsigned CNT_W bits and never wraps, because the parameter limits bound it.

Optional Feature:
Macro: WTA_RR_EN
- Defined:
  - Tie-break uses a round-robin priority pointer of IDX_W bits, reset to 0.
  - The search starts at the pointer and wraps modulo NEURONS.
  - After each win (not timeout), pointer <= (winner_idx+1) mod NEURONS.
- Undefined: fixed priority, lowest index wins, and no pointer register exists.

Test Plan:
- Reset then idle: rstb=1 for 3 cycles, then 0 -> during reset all outputs at reset values; next cycle sample_ready=1, neuron_rstb=4'b1111, busy=0.
- Single win: start pulse, then spikes=4'b0100 on 5th PRESENT cycle -> neuron_rstb=0000 for 1 cycle, signal_en high 5 cycles, latinhib high 4 cycles, then winner_valid=1, winner_idx=2, winner_none=0.
- Timeout: WIN_CYCLES=8, no spikes -> signal_en high exactly 8 cycles, latinhib never high, winner_valid=1, winner_none=1, winner_idx=0 at start+10.
- Tie and handshake: spikes=4'b1010 simultaneously -> winner_idx=1; hold winner_ack=0 for 6 cycles -> outputs stable; ack -> IDLE next cycle, winner_valid=0.
- With WTA_RR_EN: three samples each with spikes=4'b1111 -> winner_idx 0, 1, 2. Without the macro -> 0, 0, 0.
- Abort: rstb=1 during INHIBIT (2nd cycle) -> latinhib=0 next cycle, no winner_valid; start during REPORT -> ignored, no extra sample.
